stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_pkg.sv | 42 ++++
 rtl/edge_sync.sv | 29 ++
 rtl/stopwatch_counter.sv | 99 +++++++++
 tb/tb_stopwatch_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, limits and the BCD mod-60 increment used by the stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } state_t;

  typedef enum logic {
    FIELD_MIN = 1'b0,
    FIELD_SEC = 1'b1
  } field_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam bcd_t       BCD_ZERO = '{tens: 4'd0, ones: 4'd0};

  // Out-of-range digits roll to zero, so a corrupted value can never persist.
  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.ones >= ONES_MAX) begin
      r.ones = 4'd0;
      if (v.tens >= TENS_MAX) r.tens = 4'd0;
      else                    r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_is_last(input bcd_t v);
    return (v.ones == ONES_MAX) && (v.tens == TENS_MAX);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes a slow divider clock into clk and emits a one-cycle pulse per rising edge.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   pulse_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg  <= '0;
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg  <= sync_reg[SYNC_STAGES-1];
      pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with run/pause/adjust modes, counting from synchronized divider ticks.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_2hz,
  input  logic       pause_btn,
  input  logic       clr,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running
);

  logic   tick_1;
  logic   tick_2;
  state_t state_reg, state_next;
  bcd_t   min_reg, min_next;
  bcd_t   sec_reg, sec_next;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
    .clk   (clk),
    .rst   (rst),
    .din   (clk_1hz),
    .pulse (tick_1)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_2hz (
    .clk   (clk),
    .rst   (rst),
    .din   (clk_2hz),
    .pulse (tick_2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= PAUSED;
      min_reg   <= BCD_ZERO;
      sec_reg   <= BCD_ZERO;
    end else begin
      state_reg <= state_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (adj) begin
      state_next = ADJUST;
    end else begin
      case (state_reg)
        RUN:     if (pause_btn) state_next = PAUSED;
        PAUSED:  if (pause_btn) state_next = RUN;
        default: state_next = PAUSED;
      endcase
    end
  end

  // Time update uses the current state, so a tick landing with pause_btn still counts.
  always_comb begin
    min_next = min_reg;
    sec_next = sec_reg;
    if (clr) begin
      min_next = BCD_ZERO;
      sec_next = BCD_ZERO;
    end else begin
      case (state_reg)
        RUN: begin
          if (tick_1) begin
            sec_next = bcd_inc(sec_reg);
            if (bcd_is_last(sec_reg)) min_next = bcd_inc(min_reg);
          end
        end
        ADJUST: begin
          if (tick_2) begin
            if (field_t'(sel) == FIELD_SEC) sec_next = bcd_inc(sec_reg);
            else                            min_next = bcd_inc(min_reg);
          end
        end
        default: ;
      endcase
    end
  end

  assign min_t   = min_reg.tens;
  assign min_o   = min_reg.ones;
  assign sec_t   = sec_reg.tens;
  assign sec_o   = sec_reg.ones;
  assign running = (state_reg == RUN);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed vector table plus hand sequences for coincident pulses and mid-run reset.
module tb_stopwatch_counter;

  localparam int SYNC = 2;
  localparam int HOLD = SYNC + 3;

  typedef enum {OP_RESET, OP_PAUSE, OP_CLR, OP_E1, OP_E2, OP_ADJ} op_t;

  typedef struct {
    op_t         op;
    int          n;
    logic        adj_l;
    logic        sel_l;
    logic [15:0] mmss;
    logic        run;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_1hz = 1'b0;
  logic       clk_2hz = 1'b0;
  logic       pause_btn = 1'b0;
  logic       clr = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running;

  int n_assert = 0;
  int n_fail   = 0;

  vec_t vecs[25];

  stopwatch_counter #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_1hz   (clk_1hz),
    .clk_2hz   (clk_2hz),
    .pause_btn (pause_btn),
    .clr       (clr),
    .adj       (adj),
    .sel       (sel),
    .min_t     (min_t),
    .min_o     (min_o),
    .sec_t     (sec_t),
    .sec_o     (sec_o),
    .running   (running)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mmss();
    return {min_t, min_o, sec_t, sec_o};
  endfunction

  function automatic logic bcd_ok();
    logic [15:0] t;
    t = mmss();
    if ($isunknown(t) || $isunknown(running)) return 1'b0;
    return (min_t <= 4'd5) && (min_o <= 4'd9) && (sec_t <= 4'd5) && (sec_o <= 4'd9);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pulse_in(input int which);
    @(negedge clk);
    if (which == 0) pause_btn = 1'b1; else clr = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
    clr       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic edges(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 1) clk_1hz = 1'b1; else clk_2hz = 1'b1;
      repeat (HOLD) @(negedge clk);
      clk_1hz = 1'b0;
      clk_2hz = 1'b0;
      repeat (HOLD) @(negedge clk);
    end
  endtask

  // Raise clk_1hz and fire pause_btn (which=0) or clr (which=1) in the tick cycle.
  task automatic edge1_with(input int which);
    logic found;
    found = 1'b0;
    @(negedge clk);
    clk_1hz = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (dut.tick_1 === 1'b1) found = 1'b1;
    end
    check("tick_seen", {31'd0, found}, 32'd1);
    if (which == 0) pause_btn = 1'b1; else clr = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
    clr       = 1'b0;
    clk_1hz   = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic set_mode(input logic a, input logic s);
    @(negedge clk);
    adj = a;
    sel = s;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    case (v.op)
      OP_RESET: begin
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
      end
      OP_PAUSE: pulse_in(0);
      OP_CLR:   pulse_in(1);
      OP_E1:    edges(1, v.n);
      OP_E2:    edges(2, v.n);
      default:  set_mode(v.adj_l, v.sel_l);
    endcase
  endtask

  initial begin
    int tick_cycles;
    vecs[0]  = '{OP_RESET, 0,  1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{OP_PAUSE, 0,  1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{OP_E1,    61, 1'b0, 1'b0, 16'h0101, 1'b1};
    vecs[3]  = '{OP_CLR,   0,  1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[4]  = '{OP_E1,    5,  1'b0, 1'b0, 16'h0005, 1'b1};
    vecs[5]  = '{OP_PAUSE, 0,  1'b0, 1'b0, 16'h0005, 1'b0};
    vecs[6]  = '{OP_E1,    10, 1'b0, 1'b0, 16'h0005, 1'b0};
    vecs[7]  = '{OP_PAUSE, 0,  1'b0, 1'b0, 16'h0005, 1'b1};
    vecs[8]  = '{OP_E1,    1,  1'b0, 1'b0, 16'h0006, 1'b1};
    vecs[9]  = '{OP_ADJ,   0,  1'b1, 1'b0, 16'h0006, 1'b0};
    vecs[10] = '{OP_E2,    62, 1'b0, 1'b0, 16'h0206, 1'b0};
    vecs[11] = '{OP_ADJ,   0,  1'b1, 1'b1, 16'h0206, 1'b0};
    vecs[12] = '{OP_E2,    60, 1'b0, 1'b0, 16'h0206, 1'b0};
    vecs[13] = '{OP_E1,    3,  1'b0, 1'b0, 16'h0206, 1'b0};
    vecs[14] = '{OP_E2,    5,  1'b0, 1'b0, 16'h0211, 1'b0};
    vecs[15] = '{OP_ADJ,   0,  1'b0, 1'b1, 16'h0211, 1'b0};
    vecs[16] = '{OP_PAUSE, 0,  1'b0, 1'b0, 16'h0211, 1'b1};
    vecs[17] = '{OP_ADJ,   0,  1'b1, 1'b0, 16'h0211, 1'b0};
    vecs[18] = '{OP_E2,    57, 1'b0, 1'b0, 16'h5911, 1'b0};
    vecs[19] = '{OP_ADJ,   0,  1'b1, 1'b1, 16'h5911, 1'b0};
    vecs[20] = '{OP_E2,    47, 1'b0, 1'b0, 16'h5958, 1'b0};
    vecs[21] = '{OP_ADJ,   0,  1'b0, 1'b1, 16'h5958, 1'b0};
    vecs[22] = '{OP_PAUSE, 0,  1'b0, 1'b0, 16'h5958, 1'b1};
    vecs[23] = '{OP_E1,    1,  1'b0, 1'b0, 16'h5959, 1'b1};
    vecs[24] = '{OP_E1,    1,  1'b0, 1'b0, 16'h0000, 1'b1};

    for (int i = 0; i < 25; i++) begin
      apply(vecs[i]);
      check($sformatf("vec%0d_time", i), {16'd0, mmss()}, {16'd0, vecs[i].mmss});
      check($sformatf("vec%0d_running", i), {31'd0, running}, {31'd0, vecs[i].run});
      check($sformatf("vec%0d_bcd", i), {31'd0, bcd_ok()}, 32'd1);
      $display("vec %0d op=%s n=%0d time=%h running=%b", i, vecs[i].op.name(), vecs[i].n,
               mmss(), running);
    end

    // clr coincident with tick_1 at 00:09
    edges(1, 9);
    check("pre_clr_time", {16'd0, mmss()}, 32'h0009);
    edge1_with(1);
    check("clr_vs_tick_time", {16'd0, mmss()}, 32'h0000);
    check("clr_vs_tick_running", {31'd0, running}, 32'd1);
    $display("seq clr+tick time=%h running=%b", mmss(), running);

    // pause_btn coincident with tick_1 at 00:09
    edges(1, 9);
    edge1_with(0);
    check("pause_vs_tick_time", {16'd0, mmss()}, 32'h0010);
    check("pause_vs_tick_running", {31'd0, running}, 32'd0);
    $display("seq pause+tick time=%h running=%b", mmss(), running);

    // preload 12:34, run, then reset between clock edges
    set_mode(1'b1, 1'b0);
    edges(2, 12);
    set_mode(1'b1, 1'b1);
    edges(2, 24);
    set_mode(1'b0, 1'b1);
    pulse_in(0);
    check("preload_time", {16'd0, mmss()}, 32'h1234);
    check("preload_running", {31'd0, running}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_time", {16'd0, mmss()}, 32'h0000);
    check("async_rst_running", {31'd0, running}, 32'd0);
    $display("seq async reset time=%h running=%b", mmss(), running);
    clk_1hz = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_hold_time", {16'd0, mmss()}, 32'h0000);
    check("post_rst_running", {31'd0, running}, 32'd0);
    pulse_in(0);
    repeat (10) @(negedge clk);
    check("high_at_release_time", {16'd0, mmss()}, 32'h0000);
    clk_1hz = 1'b0;
    repeat (HOLD) @(negedge clk);

    // one clk_1hz edge must yield exactly one tick cycle and one increment
    tick_cycles = 0;
    clk_1hz = 1'b1;
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clk);
      if (dut.tick_1 === 1'b1) tick_cycles++;
    end
    clk_1hz = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clk);
      if (dut.tick_1 === 1'b1) tick_cycles++;
    end
    check("tick_width", tick_cycles, 32'd1);
    check("single_edge_time", {16'd0, mmss()}, 32'h0001);
    $display("seq tick width=%0d time=%h running=%b", tick_cycles, mmss(), running);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
